// File: rtl/ofdm_pkg.sv
// Shared OFDM receive definitions: transform sizes, default sample width,
// complex sample type and Hermitian demapper state encoding.
package ofdm_pkg;

    localparam int NFFT = 16;
    localparam int NSC  = 8;
    localparam int DW   = 24;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        HD_IDLE  = 2'd0,
        HD_LOWER = 2'd1,
        HD_UPPER = 2'd2
    } hd_state_t;

endpackage

// File: rtl/conj_avg.sv
// Combinational (a + conj(b)) >>> 1 with one bit of headroom, so the result
// is the floored average and can never wrap.
module conj_avg
    import ofdm_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    output cplx_t y
);

    logic signed [DW:0] sum_re;
    logic signed [DW:0] dif_im;

    always_comb begin
        sum_re = $signed({a.re[DW-1], a.re}) + $signed({b.re[DW-1], b.re});
        dif_im = $signed({a.im[DW-1], a.im}) - $signed({b.im[DW-1], b.im});
        y.re   = sum_re[DW:1];
        y.im   = dif_im[DW:1];
    end

endmodule

// File: rtl/hermitian_demap.sv
// Recovers 8 data subcarriers from a serial 16-bin FFT symbol by folding the
// Hermitian-symmetric upper half onto the buffered lower half.
//
// state    | meaning
// ---------+-------------------------------------------------------
// HD_IDLE  | waiting for en && sof (bin 0)
// HD_LOWER | storing bins 1..8 into the buffer
// HD_UPPER | folding bins 9..15 into lanes 7..1; bin 15 publishes y
module hermitian_demap
    import ofdm_pkg::*;
#(
    parameter int DW = ofdm_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sof,
    input  logic [DW-1:0] x_real,
    input  logic [DW-1:0] x_imag,
    output logic [DW-1:0] y0_real,
    output logic [DW-1:0] y1_real,
    output logic [DW-1:0] y2_real,
    output logic [DW-1:0] y3_real,
    output logic [DW-1:0] y4_real,
    output logic [DW-1:0] y5_real,
    output logic [DW-1:0] y6_real,
    output logic [DW-1:0] y7_real,
    output logic [DW-1:0] y0_imag,
    output logic [DW-1:0] y1_imag,
    output logic [DW-1:0] y2_imag,
    output logic [DW-1:0] y3_imag,
    output logic [DW-1:0] y4_imag,
    output logic [DW-1:0] y5_imag,
    output logic [DW-1:0] y6_imag,
    output logic [DW-1:0] y7_imag,
    output logic          valid,
    output logic          frame_err
);

    hd_state_t   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    cplx_t       buf_q [0:NSC];
    cplx_t       buf_d [0:NSC];
    cplx_t       y_q   [0:NSC-1];
    cplx_t       y_d   [0:NSC-1];
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;

    cplx_t       x_in;
    cplx_t       fold_y;
    logic [3:0]  k_idx;

    assign x_in  = '{re: x_real, im: x_imag};
    // Mirror bin of the incoming upper-half sample; also the slot its result reuses.
    assign k_idx = 4'(5'd16 - {1'b0, idx_q});

    conj_avg u_conj_avg (
        .a (buf_q[k_idx]),
        .b (x_in),
        .y (fold_y)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        y_d         = y_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        if (en) begin
            if (sof) begin
                frame_err_d = (state_q != HD_IDLE);
                buf_d[0]    = x_in;
                idx_d       = 4'd1;
                state_d     = HD_LOWER;
            end else begin
                case (state_q)
                    HD_LOWER: begin
                        buf_d[idx_q] = x_in;
                        idx_d        = idx_q + 4'd1;
                        if (idx_q == 4'(NSC)) state_d = HD_UPPER;
                    end
                    HD_UPPER: begin
                        if (idx_q == 4'(NFFT-1)) begin
                            y_d[0] = '{re: buf_q[0].re, im: buf_q[NSC].re};
                            y_d[1] = fold_y;
                            for (int k = 2; k < NSC; k++) y_d[k] = buf_q[k];
                            valid_d = 1'b1;
                            idx_d   = 4'd0;
                            state_d = HD_IDLE;
                        end else begin
                            buf_d[k_idx] = fold_y;
                            idx_d        = idx_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HD_IDLE;
            idx_q       <= 4'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k <= NSC; k++) buf_q[k] <= '0;
            for (int k = 0; k < NSC; k++)  y_q[k]   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            buf_q       <= buf_d;
            y_q         <= y_d;
        end
    end

    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign y0_real   = y_q[0].re;
    assign y1_real   = y_q[1].re;
    assign y2_real   = y_q[2].re;
    assign y3_real   = y_q[3].re;
    assign y4_real   = y_q[4].re;
    assign y5_real   = y_q[5].re;
    assign y6_real   = y_q[6].re;
    assign y7_real   = y_q[7].re;
    assign y0_imag   = y_q[0].im;
    assign y1_imag   = y_q[1].im;
    assign y2_imag   = y_q[2].im;
    assign y3_imag   = y_q[3].im;
    assign y4_imag   = y_q[4].im;
    assign y5_imag   = y_q[5].im;
    assign y6_imag   = y_q[6].im;
    assign y7_imag   = y_q[7].im;

endmodule

// File: tb/tb_hermitian_demap.sv
// Directed bench for hermitian_demap: inputs driven and outputs sampled on the
// falling edge, expected lane values written out by hand per symbol.
module tb_hermitian_demap;

    logic clk = 1'b0;
    logic reset, en, sof;
    logic signed [23:0] xr, xi;
    logic signed [23:0] yr [8];
    logic signed [23:0] yi [8];
    logic valid, frame_err;

    int total = 0;
    int bad   = 0;

    logic signed [23:0] sr [16];
    logic signed [23:0] si [16];
    longint er [8];
    longint ei [8];
    longint hold_y1 = 0;

    always #5 clk = ~clk;

    hermitian_demap dut (
        .clk (clk), .reset (reset), .en (en), .sof (sof),
        .x_real (xr), .x_imag (xi),
        .y0_real (yr[0]), .y1_real (yr[1]), .y2_real (yr[2]), .y3_real (yr[3]),
        .y4_real (yr[4]), .y5_real (yr[5]), .y6_real (yr[6]), .y7_real (yr[7]),
        .y0_imag (yi[0]), .y1_imag (yi[1]), .y2_imag (yi[2]), .y3_imag (yi[3]),
        .y4_imag (yi[4]), .y5_imag (yi[5]), .y6_imag (yi[6]), .y7_imag (yi[7]),
        .valid (valid), .frame_err (frame_err)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic signed [23:0] re, input logic signed [23:0] im, input logic s);
        en = 1'b1; sof = s; xr = re; xi = im;
        @(negedge clk);
        en = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("idle_valid", valid, 0);
        end
    endtask

    // Sends sr/si as one symbol; y1 must hold its old value until bin 15.
    task automatic send_cur(input bit gap);
        for (int b = 0; b < 16; b++) begin
            put(sr[b], si[b], b == 0);
            if (b < 15) begin
                chk("mid_valid", valid, 0);
                chk("mid_ferr", frame_err, 0);
                chk("mid_hold_y1", yr[1], hold_y1);
                if (gap && (b == 4 || b == 12)) idle(3);
            end
        end
        chk("end_valid", valid, 1);
        chk("end_ferr", frame_err, 0);
    endtask

    task automatic chk_lanes(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_re"}, yr[k], er[k]);
            chk({tag, "_im"}, yi[k], ei[k]);
        end
        hold_y1 = er[1];
    endtask

    task automatic load_std();
        sr[0] = 24'sd500;  si[0] = 24'sd7;
        sr[8] = -24'sd300; si[8] = 24'sd9;
        for (int k = 1; k < 8; k++) begin
            sr[k]    = 24'(100*k); si[k]    = 24'(10*k);
            sr[16-k] = 24'(100*k); si[16-k] = 24'(-10*k);
        end
        er[0] = 500; ei[0] = -300;
        for (int k = 1; k < 8; k++) begin er[k] = 100*k; ei[k] = 10*k; end
    endtask

    task automatic load_zero();
        for (int b = 0; b < 16; b++) begin sr[b] = '0; si[b] = '0; end
        for (int k = 0; k < 8; k++) begin er[k] = 0; ei[k] = 0; end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; sof = 1'b0; xr = '0; xi = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_y0r", yr[0], 0);
        chk("rst_y7i", yi[7], 0);
        reset = 1'b0;
        idle(2);

        // Symmetric symbol, contiguous
        load_std();
        send_cur(1'b0);
        chk_lanes("sym");
        @(negedge clk);
        chk("sym_pulse", valid, 0);

        // Same symbol with gaps after bins 4 and 12
        send_cur(1'b1);
        chk_lanes("gap");
        idle(1);

        // Floor of (3+0)/2 and (1-0)/2
        load_zero();
        sr[3] = 24'sd3; si[3] = 24'sd1;
        er[3] = 1; ei[3] = 0;
        send_cur(1'b0);
        chk_lanes("round");
        idle(1);

        // Full-scale fold must not wrap
        load_zero();
        sr[3]  = 24'sd8388607; si[3]  = -24'sd8388608;
        sr[13] = 24'sd8388607; si[13] = -24'sd8388608;
        er[3] = 8388607; ei[3] = 0;
        send_cur(1'b0);
        chk_lanes("ext");
        idle(1);

        // Resync: sof on bin 10 aborts, that sample becomes bin 0 of a clean symbol
        load_std();
        for (int b = 0; b < 10; b++) put(sr[b], si[b], b == 0);
        put(sr[0], si[0], 1'b1);
        chk("resync_ferr", frame_err, 1);
        chk("resync_novalid", valid, 0);
        for (int b = 1; b < 16; b++) begin
            put(sr[b], si[b], 1'b0);
            if (b < 15) begin
                chk("resync_mid_ferr", frame_err, 0);
                chk("resync_mid_valid", valid, 0);
            end
        end
        chk("resync_valid", valid, 1);
        chk_lanes("resync");
        idle(1);

        // Reset while bin 6 is presented
        for (int b = 0; b < 6; b++) put(sr[b], si[b], b == 0);
        reset = 1'b1; en = 1'b1; xr = sr[6]; xi = si[6];
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        chk("mrst_valid", valid, 0);
        chk("mrst_ferr", frame_err, 0);
        chk("mrst_y0r", yr[0], 0);
        chk("mrst_y3r", yr[3], 0);
        chk("mrst_y5i", yi[5], 0);
        hold_y1 = 0;
        for (int b = 7; b < 10; b++) begin
            put(sr[b], si[b], 1'b0);
            chk("drop_valid", valid, 0);
            chk("drop_ferr", frame_err, 0);
        end
        send_cur(1'b0);
        chk_lanes("postrst");
        idle(1);

        // Back-to-back: standard symbol then symbol B with negative odd sums
        send_cur(1'b0);
        chk_lanes("b2b_a");
        sr[0] = -24'sd1000; si[0] = 24'sd0;
        sr[8] = 24'sd1234;  si[8] = 24'sd0;
        for (int k = 1; k < 8; k++) begin
            sr[k]    = 24'(-50*k);     si[k]    = 24'(20*k);
            sr[16-k] = 24'(-50*k + 1); si[16-k] = 24'(-20*k + 3);
        end
        er[0] = -1000; ei[0] = 1234;
        for (int k = 1; k < 8; k++) begin er[k] = -50*k; ei[k] = 20*k - 2; end
        send_cur(1'b0);
        chk_lanes("b2b_b");
        @(negedge clk);
        chk("b2b_pulse", valid, 0);
        chk("b2b_hold_y2", yr[2], -100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
